// File: rtl/arr_check_sched_if.sv
// Handshake/bus bundle between the stimulus side and the arr check scheduler.
// master = stimulus side, slave = scheduler.
interface arr_check_sched_if #(
    parameter int N_ARR   = 6,
    parameter int MAX_LEN = 6
);
    localparam int IDX_W = (N_ARR > 1) ? $clog2(N_ARR) : 1;

    logic                       en;
    logic [N_ARR-1:0]           req;
    logic                       clr;
    logic [N_ARR*MAX_LEN-1:0]   sig_flat;
    logic [N_ARR*MAX_LEN-1:0]   rfr_flat;
    logic [N_ARR-1:0]           check_o;
    logic                       busy;
    logic                       done;
    logic [IDX_W-1:0]           done_idx;
    logic                       done_fail;
    logic [N_ARR-1:0]           fail_mask;
    logic [15:0]                mismatch_cnt;

    modport master (
        output en, req, clr, sig_flat, rfr_flat,
        input  check_o, busy, done, done_idx, done_fail, fail_mask, mismatch_cnt
    );

    modport slave (
        input  en, req, clr, sig_flat, rfr_flat,
        output check_o, busy, done, done_idx, done_fail, fail_mask, mismatch_cnt
    );
endinterface

// File: rtl/arr_check_sched.sv
// Round-robin scheduler for the arr[] check strobes: grants one instance at a time,
// holds its check line, then compares the instance's sig/rfr bits and logs the result.
module arr_check_sched #(
    parameter int N_ARR       = 6,
    parameter int MAX_LEN     = 6,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    arr_check_sched_if.slave  bus
);
    localparam int IDX_W = (N_ARR > 1) ? $clog2(N_ARR) : 1;

    typedef enum logic [1:0] {IDLE, ARM, CMP} state_t;

    state_t             state_q, state_d;
    logic [N_ARR-1:0]   pending_q;
    logic [IDX_W-1:0]   last_grant_q;
    logic [IDX_W-1:0]   grant_q;
    logic [3:0]         hold_q;
    logic [N_ARR-1:0]   fail_mask_q;
    logic [15:0]        mismatch_cnt_q;

    logic [IDX_W-1:0]   arb_idx;
    logic               arb_found;
    logic               do_grant;
    logic [N_ARR-1:0]   grant_clr;
    logic [N_ARR-1:0]   grant_onehot;
    logic [MAX_LEN-1:0] sig_slot, rfr_slot, cmp_mask;
    logic               mismatch;

    // Round-robin search starting one past the last granted instance.
    always_comb begin
        int cand;
        // NOTE: every comb output gets a default first so no path can infer a latch.
        arb_idx   = '0;
        arb_found = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N_ARR; k++) begin
            cand = (int'(last_grant_q) + k) % N_ARR;
            if (!arb_found && pending_q[IDX_W'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(cand);
            end
        end
    end

    assign do_grant     = (state_q == IDLE) && bus.en && arb_found;
    assign grant_clr    = do_grant ? (N_ARR'(1) << arb_idx) : '0;
    assign grant_onehot = N_ARR'(1) << grant_q;

    // Only bits [g:0] of the granted slot are meaningful for instance g.
    always_comb begin
        sig_slot = '0;
        rfr_slot = '0;
        cmp_mask = '0;
        for (int i = 0; i < N_ARR; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sig_slot = bus.sig_flat[i*MAX_LEN +: MAX_LEN];
                rfr_slot = bus.rfr_flat[i*MAX_LEN +: MAX_LEN];
            end
        end
        for (int b = 0; b < MAX_LEN; b++) begin
            cmp_mask[b] = (b <= int'(grant_q));
        end
    end

    assign mismatch = |((sig_slot ^ rfr_slot) & cmp_mask);

    // State register, grant bookkeeping and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q      <= IDLE;
            pending_q    <= '0;
            last_grant_q <= IDX_W'(N_ARR - 1);
            grant_q      <= '0;
            hold_q       <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= (pending_q & ~grant_clr) | bus.req;
            if (do_grant) begin
                grant_q      <= arb_idx;
                last_grant_q <= arb_idx;
            end
            hold_q <= (state_q == ARM) ? hold_q + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_grant) state_d = ARM;
            ARM:     if (hold_q == 4'(HOLD_CYCLES - 1)) state_d = CMP;
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.check_o   = (state_q == ARM) ? grant_onehot : '0;
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == CMP);
        bus.done_idx  = (state_q == CMP) ? grant_q : '0;
        bus.done_fail = (state_q == CMP) && mismatch;
    end

    // A failure coincident with clr leaves only the fresh failure recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_mask_q    <= '0;
            mismatch_cnt_q <= '0;
        end else if (state_q == CMP && mismatch) begin
            if (bus.clr) begin
                fail_mask_q    <= grant_onehot;
                mismatch_cnt_q <= 16'd1;
            end else begin
                fail_mask_q <= fail_mask_q | grant_onehot;
                if (mismatch_cnt_q != 16'hFFFF) mismatch_cnt_q <= mismatch_cnt_q + 16'd1;
            end
        end else if (bus.clr) begin
            fail_mask_q    <= '0;
            mismatch_cnt_q <= '0;
        end
    end

    assign bus.fail_mask    = fail_mask_q;
    assign bus.mismatch_cnt = mismatch_cnt_q;
endmodule

// File: tb/tb_arr_check_sched.sv
// Self-checking bench for arr_check_sched: scoreboard of expected done results
// plus a vector table of single-instance compares and hand-written corner sequences.
module tb_arr_check_sched;
    localparam int N_ARR = 6;
    localparam int MAX_LEN = 6;
    localparam int W = N_ARR * MAX_LEN;

    typedef struct {
        int         idx;
        logic [5:0] sig;
        logic [5:0] rfr;
        bit         exp_fail;
    } vec_t;

    typedef struct {
        int idx;
        bit fail;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[6];

    arr_check_sched_if #(.N_ARR(N_ARR), .MAX_LEN(MAX_LEN)) bus ();

    arr_check_sched #(.N_ARR(N_ARR), .MAX_LEN(MAX_LEN), .HOLD_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n) begin
            check("check_o_onehot", 32'($countones(bus.check_o) <= 1), 32'd1);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got idx %0d expected no done", bus.done_idx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_idx", 32'(bus.done_idx), 32'(e.idx));
                    check("done_fail", 32'(bus.done_fail), 32'(e.fail));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [N_ARR-1:0] v);
        bus.req = v;
        tick();
        bus.req = '0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            if (!bus.busy && sb.size() == 0) break;
            tick();
        end
        if (i == max_cycles) check("wait_idle_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [W-1:0] slot(input int idx, input logic [5:0] v);
        logic [W-1:0] r;
        r = '0;
        r[idx*MAX_LEN +: MAX_LEN] = v;
        return r;
    endfunction

    initial begin
        logic [N_ARR-1:0] exp_mask;
        int               exp_cnt;
        int               i;

        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.req      = '0;
        bus.clr      = 1'b0;
        bus.sig_flat = '0;
        bus.rfr_flat = '0;
        #1;
        check("rst_check_o", 32'(bus.check_o), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_fail_mask", 32'(bus.fail_mask), 32'd0);
        check("rst_mismatch_cnt", 32'(bus.mismatch_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request on slot 2: exact cycle-by-cycle latency.
        bus.sig_flat = slot(2, 6'b000101);
        bus.rfr_flat = slot(2, 6'b000101);
        sb.push_back('{idx: 2, fail: 1'b0});
        pulse(6'b000100);
        check("t1_idle_check_o", 32'(bus.check_o), 32'd0);
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        tick();
        check("t1_arm1_check_o", 32'(bus.check_o), 32'b000100);
        check("t1_arm1_busy", 32'(bus.busy), 32'd1);
        tick();
        check("t1_arm2_check_o", 32'(bus.check_o), 32'b000100);
        tick();
        check("t1_cmp_check_o", 32'(bus.check_o), 32'd0);
        check("t1_cmp_done", 32'(bus.done), 32'd1);
        tick();
        check("t1_busy_after", 32'(bus.busy), 32'd0);
        check("t1_fail_mask", 32'(bus.fail_mask), 32'd0);

        // All six requested at once after reset: service order 0..5.
        do_reset();
        bus.sig_flat = '0;
        bus.rfr_flat = '0;
        for (int k = 0; k < N_ARR; k++) sb.push_back('{idx: k, fail: 1'b0});
        pulse(6'b111111);
        wait_idle(100);
        check("t2_sb_drained", 32'(sb.size()), 32'd0);

        // Vector table: compare window is bits [g:0] of slot g.
        vecs[0] = '{idx: 0, sig: 6'b111110, rfr: 6'b000000, exp_fail: 1'b0};
        vecs[1] = '{idx: 5, sig: 6'b100000, rfr: 6'b000000, exp_fail: 1'b1};
        vecs[2] = '{idx: 3, sig: 6'b010000, rfr: 6'b000000, exp_fail: 1'b0};
        vecs[3] = '{idx: 3, sig: 6'b001000, rfr: 6'b000000, exp_fail: 1'b1};
        vecs[4] = '{idx: 1, sig: 6'b000011, rfr: 6'b000011, exp_fail: 1'b0};
        vecs[5] = '{idx: 4, sig: 6'b000000, rfr: 6'b000001, exp_fail: 1'b1};
        exp_mask = '0;
        exp_cnt  = 0;
        foreach (vecs[v]) begin
            bus.sig_flat = slot(vecs[v].idx, vecs[v].sig);
            bus.rfr_flat = slot(vecs[v].idx, vecs[v].rfr);
            sb.push_back('{idx: vecs[v].idx, fail: vecs[v].exp_fail});
            pulse(N_ARR'(1) << vecs[v].idx);
            wait_idle(20);
            if (vecs[v].exp_fail) begin
                exp_mask[vecs[v].idx] = 1'b1;
                exp_cnt++;
            end
            check("t3_fail_mask", 32'(bus.fail_mask), 32'(exp_mask));
            check("t3_mismatch_cnt", 32'(bus.mismatch_cnt), 32'(exp_cnt));
        end

        // en=0 holds the request; a re-request during ARM gets a second check.
        bus.sig_flat = '0;
        bus.rfr_flat = '0;
        bus.en = 1'b0;
        pulse(6'b001000);
        for (int k = 0; k < 8; k++) tick();
        check("t4_no_grant_busy", 32'(bus.busy), 32'd0);
        check("t4_no_grant_check_o", 32'(bus.check_o), 32'd0);
        sb.push_back('{idx: 3, fail: 1'b0});
        sb.push_back('{idx: 3, fail: 1'b0});
        bus.en = 1'b1;
        for (i = 0; i < 20; i++) begin
            if (bus.check_o != 0) break;
            tick();
        end
        check("t4_arm_check_o", 32'(bus.check_o), 32'b001000);
        pulse(6'b001000);
        wait_idle(40);
        check("t4_sb_drained", 32'(sb.size()), 32'd0);

        // Saturation near the top of the counter, then clr coincident with a failure.
        bus.sig_flat = slot(0, 6'b000001);
        bus.rfr_flat = '0;
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("t5_clr_mask", 32'(bus.fail_mask), 32'd0);
        check("t5_clr_cnt", 32'(bus.mismatch_cnt), 32'd0);
        force dut.mismatch_cnt_q = 16'hFFFE;
        tick();
        tick();
        release dut.mismatch_cnt_q;
        tick();
        check("t5_preload_cnt", 32'(bus.mismatch_cnt), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{idx: 0, fail: 1'b1});
            pulse(6'b000001);
            wait_idle(20);
        end
        check("t5_saturated_cnt", 32'(bus.mismatch_cnt), 32'hFFFF);
        check("t5_sat_mask", 32'(bus.fail_mask), 32'b000001);
        bus.sig_flat = slot(5, 6'b000001);
        sb.push_back('{idx: 5, fail: 1'b1});
        pulse(6'b100000);
        for (i = 0; i < 20; i++) begin
            if (bus.busy && bus.check_o == 0) break;
            tick();
        end
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("t5_clr_fail_cnt", 32'(bus.mismatch_cnt), 32'd1);
        check("t5_clr_fail_mask", 32'(bus.fail_mask), 32'b100000);
        wait_idle(20);

        // Reset during ARM: strobe drops at once, no done; next search starts at index 0.
        bus.sig_flat = '0;
        pulse(6'b000100);
        for (i = 0; i < 20; i++) begin
            if (bus.check_o != 0) break;
            tick();
        end
        check("t6_arm_before_rst", 32'(bus.check_o), 32'b000100);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_check_o", 32'(bus.check_o), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_rst_mask", 32'(bus.fail_mask), 32'd0);
        check("t6_rst_cnt", 32'(bus.mismatch_cnt), 32'd0);
        sb.push_back('{idx: 1, fail: 1'b0});
        sb.push_back('{idx: 5, fail: 1'b0});
        pulse(6'b100010);
        wait_idle(40);
        check("t6_sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
